// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the M-extension divide sequencer.
package common_pkg;

   localparam int DIV_XLEN    = 32;
   localparam int DIV_LATENCY = DIV_XLEN + 3;

   typedef enum logic [1:0] {
      DIV_S = 2'b00,
      DIV_U = 2'b01,
      REM_S = 2'b10,
      REM_U = 2'b11
   } div_op_t;

   typedef enum logic [2:0] {
      DIV_IDLE  = 3'd0,
      DIV_PREP  = 3'd1,
      DIV_RUN   = 3'd2,
      DIV_FIXUP = 3'd3,
      DIV_DONE  = 3'd4
   } div_state_t;

   function automatic logic op_is_signed(div_op_t op);
      return (op == DIV_S) || (op == REM_S);
   endfunction

   function automatic logic op_is_rem(div_op_t op);
      return (op == REM_S) || (op == REM_U);
   endfunction

endpackage

// File: rtl/div_sequencer_div_step.sv
// One radix-2 restoring divide iteration on unsigned magnitudes.
module div_step
   import common_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Shift {rem,quo} left, trial-subtract in XLEN+1 bits and restore when the difference is negative
   always_comb begin
      shifted  = {rem, quo[XLEN-1]};
      diff     = shifted - {1'b0, divisor};
      quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
      rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: FSM, iteration counter, sign tracking and result registers.
module div_sequencer
   import common_pkg::*;
#(
   parameter int XLEN = DIV_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   input  logic [4:0]      rd_id_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_id_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t      state_q, state_d;
   div_op_t         op_q;
   logic [XLEN-1:0] a_q, b_q;
   logic [XLEN-1:0] quo_q, rem_q, dvs_q;
   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_q, rd_out_q;
   logic [CNT_W-1:0] cnt_q;
   logic            neg_quo_q, neg_rem_q;

   logic            accept, op_signed, a_neg, b_neg, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_quo, spec_rem, fix_quo, fix_rem;
   logic [XLEN-1:0] step_rem, step_quo;

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   // Operand magnitudes, fast-path detection and final sign correction
   always_comb begin
      accept    = ((state_q == DIV_IDLE) || (state_q == DIV_DONE)) && start_i && !flush_i;
      op_signed = op_is_signed(op_q);
      a_neg     = op_signed & a_q[XLEN-1];
      b_neg     = op_signed & b_q[XLEN-1];
      a_mag     = a_neg ? -a_q : a_q;
      b_mag     = b_neg ? -b_q : b_q;
      special   = (b_q == '0) || (op_signed && (a_q == MIN_NEG) && (b_q == '1));
      spec_quo  = (b_q == '0) ? '1 : MIN_NEG;
      spec_rem  = (b_q == '0) ? a_q : '0;
      fix_quo   = neg_quo_q ? -quo_q : quo_q;
      fix_rem   = neg_rem_q ? -rem_q : rem_q;
   end

   // Next-state and status outputs; a flush overrides every transition
   always_comb begin
      state_d = state_q;
      ready_o = 1'b0;
      stall_o = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            ready_o = 1'b1;
            if (accept) state_d = DIV_PREP;
         end
         DIV_PREP: begin
            stall_o = 1'b1;
            // Fast-path results pass through FIXUP so there is a single result-register write point
            state_d = special ? DIV_FIXUP : DIV_RUN;
         end
         DIV_RUN: begin
            stall_o = 1'b1;
            if (cnt_q == '0) state_d = DIV_FIXUP;
         end
         DIV_FIXUP: begin
            stall_o = 1'b1;
            state_d = DIV_DONE;
         end
         DIV_DONE: begin
            ready_o = 1'b1;
            done_o  = 1'b1;
            state_d = accept ? DIV_PREP : DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush_i) state_d = DIV_IDLE;
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= DIV_IDLE;
      else        state_q <= state_d;
   end

   // Request capture, iteration datapath, counter and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q      <= DIV_S;
         a_q       <= '0;
         b_q       <= '0;
         rd_q      <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
         rd_out_q  <= '0;
      end else begin
         case (state_q)
            DIV_IDLE, DIV_DONE: begin
               if (accept) begin
                  op_q <= div_op_t'(op_i);
                  a_q  <= dividend_i;
                  b_q  <= divisor_i;
                  rd_q <= rd_id_i;
               end
            end
            DIV_PREP: begin
               if (special) begin
                  quo_q     <= spec_quo;
                  rem_q     <= spec_rem;
                  neg_quo_q <= 1'b0;
                  neg_rem_q <= 1'b0;
               end else begin
                  quo_q     <= a_mag;
                  rem_q     <= '0;
                  dvs_q     <= b_mag;
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= CNT_W'(XLEN-1);
               end
            end
            DIV_RUN: begin
               quo_q <= step_quo;
               rem_q <= step_rem;
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            DIV_FIXUP: begin
               if (!flush_i) begin
                  result_q <= op_is_rem(op_q) ? fix_rem : fix_quo;
                  rd_out_q <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_o = result_q;
   assign rd_id_o  = rd_out_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking scoreboard bench for div_sequencer.
module tb_div_sequencer;
   import common_pkg::*;

   localparam int XLEN = 32;

   typedef struct {
      string       name;
      logic [31:0] result;
      logic [4:0]  rd;
      int          latency;
      int          stall_base;
      int          acc_edge;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  rd_id_i;
   logic        flush_i;
   logic        ready_o;
   logic        stall_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_id_o;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cycle = 0;
   int          stall_cnt = 0;
   logic [31:0] last_result = '0;

   div_sequencer #(.XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .op_i       (op_i),
      .dividend_i (dividend_i),
      .divisor_i  (divisor_i),
      .rd_id_i    (rd_id_i),
      .flush_i    (flush_i),
      .ready_o    (ready_o),
      .stall_o    (stall_o),
      .done_o     (done_o),
      .result_o   (result_o),
      .rd_id_o    (rd_id_o)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter used for latency measurement
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // RISC-V M-extension divide semantics
   function automatic logic [31:0] refModel(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'b00:   if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return $signed(a) / $signed(b);
         2'b01:   if (b == 0) return 32'hFFFF_FFFF; else return a / b;
         2'b10:   if (b == 0) return a; else if (ovf) return 32'h0; else return $signed(a) % $signed(b);
         default: if (b == 0) return a; else return a % b;
      endcase
   endfunction

   function automatic int expLatency(logic [1:0] op, logic [31:0] a, logic [31:0] b);
      logic sgn;
      sgn = (op == 2'b00) || (op == 2'b10);
      if ((b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
      return XLEN + 2;
   endfunction

   // Drive a request and hold start_i until the DUT is ready; returns the accepting edge number
   task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd, input bit expect_done,
                                output int acc_edge);
      int waited;
      exp_t e;
      @(negedge clk);
      op_i = op; dividend_i = a; divisor_i = b; rd_id_i = rd; start_i = 1'b1;
      waited = 0;
      while (!ready_o && waited < 2*DIV_LATENCY) begin
         @(negedge clk);
         waited++;
      end
      if (!ready_o) begin
         checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
         start_i = 1'b0;
         acc_edge = -1;
      end else begin
         acc_edge = cycle + 1;
         if (expect_done) begin
            e.name = tag;
            e.result = refModel(op, a, b);
            e.rd = rd;
            e.latency = expLatency(op, a, b);
            e.stall_base = stall_cnt;
            e.acc_edge = acc_edge;
            sb.push_back(e);
         end
         @(posedge clk);
      end
   endtask

   task automatic releaseStart();
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic waitDrain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 3*DIV_LATENCY) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0) begin
         checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"}, 32'(ready_o), 32'd1);
      checkOutput({tag, "_stall"}, 32'(stall_o), 32'd0);
      checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
      checkOutput({tag, "_result"}, result_o, 32'd0);
      checkOutput({tag, "_rd"}, 32'(rd_id_o), 32'd0);
   endtask

   // Completion monitor: pops the scoreboard on each done pulse and counts stall cycles
   always @(negedge clk) begin
      if (rst_n) begin
         if (done_o) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput({e.name, "_result"}, result_o, e.result);
               checkOutput({e.name, "_rd"}, 32'(rd_id_o), 32'(e.rd));
               checkOutput({e.name, "_latency"}, 32'(cycle - e.acc_edge), 32'(e.latency));
               checkOutput({e.name, "_stall"}, 32'(stall_cnt - e.stall_base), 32'(e.latency));
               last_result = e.result;
            end
         end
         if (stall_o) stall_cnt++;
      end
   end

   // Hard stop if the sequence ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc, acc1, acc2;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      rst_n = 1'b0; start_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
      rd_id_i = '0; flush_i = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;

      applyStimulus("divu_100_7", DIV_U, 32'd100, 32'd7, 5'd3, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("rem_m7_2", REM_S, -32'sd7, 32'd2, 5'd4, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("div_m7_2", DIV_S, -32'sd7, 32'd2, 5'd5, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("div_by0", DIV_S, 32'd12345, 32'd0, 5'd6, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("remu_by0", REM_U, 32'd5, 32'd0, 5'd7, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("div_ovf", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, acc);
      releaseStart(); waitDrain();
      applyStimulus("rem_ovf", REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, acc);
      releaseStart(); waitDrain();

      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 31);
         applyStimulus($sformatf("rand%0d", i), rop, ra, rb, 5'(10 + i), 1'b1, acc);
         releaseStart(); waitDrain();
      end

      // Flush during RUN cycle 10: back to IDLE, no done, result untouched
      applyStimulus("flush_op", DIV_S, 32'd1000, 32'd3, 5'd20, 1'b0, acc);
      releaseStart();
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      checkOutput("flush_ready", 32'(ready_o), 32'd1);
      checkOutput("flush_stall", 32'(stall_o), 32'd0);
      checkOutput("flush_result", result_o, last_result);
      repeat (XLEN + 4) @(negedge clk);
      applyStimulus("post_flush", DIV_U, 32'd999, 32'd9, 5'd21, 1'b1, acc);
      releaseStart(); waitDrain();

      // Flush and start together: the start is dropped
      @(negedge clk);
      op_i = DIV_U; dividend_i = 32'd50; divisor_i = 32'd5; rd_id_i = 5'd22;
      start_i = 1'b1; flush_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      checkOutput("flush_start_ready", 32'(ready_o), 32'd1);
      checkOutput("flush_start_stall", 32'(stall_o), 32'd0);
      repeat (4) @(negedge clk);

      // Back-to-back: second request accepted in the DONE cycle of the first
      applyStimulus("b2b_first", DIV_U, 32'd1000, 32'd10, 5'd23, 1'b1, acc1);
      applyStimulus("b2b_second", REM_S, -32'sd100, 32'd7, 5'd24, 1'b1, acc2);
      checkOutput("b2b_accept_edge", 32'(acc2), 32'(acc1 + XLEN + 3));
      releaseStart(); waitDrain();

      // Reset mid-RUN discards the op and restores reset outputs
      applyStimulus("reset_op", DIV_S, 32'd77, 32'd5, 5'd25, 1'b0, acc);
      releaseStart();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("mid_run_reset");
      rst_n = 1'b1;
      applyStimulus("post_reset", DIV_S, -32'sd77, 32'd5, 5'd26, 1'b1, acc);
      releaseStart(); waitDrain();

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
